serial_init_port_fsm: RTL and testbench
=======================================

// Module: serial_init_port_fsm
// PURPOSE
// Parametrised serial-bus initiator port: accepts one command (read/write), arbitrates, shifts
// address then data LSB-first on a 1-bit bus, and collects read data. Waits for target ack,
// supports split transactions with re-arbitration, and reports timeout errors.
// Sits between an initiator core and the bus arbiter/target-facing serial mux.
// PARAMETERS
// ADDR_W     16   address width in bits, shifted on bus_tx (range 1..32)
// DATA_W     8    data width in bits, shifted on bus_tx / bus_rx (range 1..32)
// TIMEOUT    64   max idle cycles in WAIT_ACK/RX before error (>=2)
// PORTS
// clk          in   1       clock, rising edge
// rst_n        in   1       asynchronous, active-low reset
// cmd_valid    in   1       command present
// cmd_ready    out  1       port idle, command accepted when cmd_valid&&cmd_ready
// cmd_rw       in   1       1=write, 0=read
// cmd_addr     in   ADDR_W  target address
// cmd_wdata    in   DATA_W  write data
// rsp_valid    out  1       one-cycle completion pulse
// rsp_rdata    out  DATA_W  read data (valid with rsp_valid, read only; 0 for writes)
// rsp_err      out  1       timeout flag, valid with rsp_valid
// arb_req      out  1       bus request to arbiter
// arb_grant    in   1       arbiter grant
// bus_tx       out  1       serial address/data bit
// bus_tx_valid out  1       bus_tx qualifier
// bus_mode     out  1       0=address phase, 1=data phase
// bus_rw       out  1       latched cmd_rw, held from accept to completion
// bus_rx       in   1       serial read-data bit
// bus_rx_valid in   1       bus_rx qualifier
// tgt_ack      in   1       target acknowledges write completion
// tgt_split    in   1       target requests split (pulse)
// split_resume in   1       split target ready to continue (pulse)
// BEHAVIOUR
// - Reset: state IDLE; cmd_ready=1; all other outputs 0; shift regs/counters cleared.
//   Reset mid-transfer aborts with no rsp_valid; outputs return to reset values at once.
// - All outputs registered. States: IDLE, REQ, ADDR, WDATA, WAIT_ACK, RX, SPLIT, RESP.
// - IDLE: cmd_ready=1. On accept at cycle T, latch addr/wdata/rw and go to REQ.
//   cmd_ready=0 from T+1 until the cycle after RESP.
// - REQ: arb_req=1. First cycle with arb_grant=1 -> ADDR; first address bit on bus_tx at next cycle.
//   arb_req stays 1 through ADDR/WDATA/WAIT_ACK/RX and drops in RESP/SPLIT/IDLE.
//   arb_grant is sampled only in REQ.
// - ADDR: ADDR_W consecutive cycles, bus_tx_valid=1, bus_mode=0, bit i at cycle i (LSB first).
//   Then write -> WDATA, read -> RX.
// - WDATA: DATA_W cycles, bus_tx_valid=1, bus_mode=1, LSB first, then WAIT_ACK.
// - WAIT_ACK: bus_tx_valid=0, bus_mode=1.
//   - tgt_ack -> RESP, err=0.
//   - TIMEOUT cycles without ack -> RESP, err=1.
// - RX: bus_mode=1. Each bus_rx_valid stores bus_rx at bit index cnt (LSB first).
//   - After the DATA_W-th bit -> RESP with rdata.
//   - Timeout counter restarts on every valid bit; TIMEOUT cycles with no bit -> RESP, err=1,
//     rdata=partial bits.
// - Split: tgt_split in WAIT_ACK or RX -> SPLIT (arb_req=0, timer frozen, RX bits kept).
//   - split_resume -> REQ. On grant, return to the saved state with timeout cleared.
//   - The address is NOT resent.
//   - tgt_split and tgt_ack/last bit in the same cycle: completion wins.
// - RESP: rsp_valid=1 for one cycle, then IDLE.
// - Counters sized $clog2(max(ADDR_W,DATA_W,TIMEOUT)+1); no wrap possible within a phase.
// - tgt_ack/bus_rx_valid outside WAIT_ACK/RX are ignored. split_resume outside SPLIT is ignored.
// TESTING
// - Write 0xA5 @0x1234, grant 2 cycles after arb_req, ack 3 cycles after last data bit
//   -> 16 bus_tx bits 0x1234 LSB-first (mode 0), 8 bits 0xA5 (mode 1), rsp_valid err=0.
// - Read @0x00F0, target sends 0x3C bits LSB-first with gaps -> rsp_valid, rsp_rdata=0x3C, err=0.
// - Write with no tgt_ack -> rsp_valid exactly TIMEOUT cycles after WAIT_ACK entry, rsp_err=1.
// - Read, tgt_split after 3 bits, split_resume 10 cycles later
//   -> arb_req low during SPLIT, no address resent, rdata correct after remaining 5 bits.
// - cmd_valid held high during a transaction -> second command accepted only after rsp_valid;
//   no overlap.
// - rst_n asserted mid-ADDR -> bus_tx_valid/arb_req=0 immediately, no rsp_valid,
//   next command works normally.

Source files
------------

// File: rtl/serial_init_port_fsm.sv
// Serial-bus initiator port: one read/write command, arbitrate, shift addr/data LSB-first, collect read data.
// All outputs registered; first address bit one cycle after grant; cmd_ready low from accept until after the response.
module serial_init_port_fsm #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              arb_req,
   input  logic              arb_grant,
   output logic              bus_tx,
   output logic              bus_tx_valid,
   output logic              bus_mode,
   output logic              bus_rw,
   input  logic              bus_rx,
   input  logic              bus_rx_valid,
   input  logic              tgt_ack,
   input  logic              tgt_split,
   input  logic              split_resume
);

   localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int MAXV = (MAXW > TIMEOUT) ? MAXW : TIMEOUT;
   localparam int CW   = $clog2(MAXV + 1);
   localparam int TW   = ADDR_W + DATA_W;

   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_W - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] TMR_LAST  = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, REQ, ADDR, WDATA, WAIT_ACK, RX, SPLIT, RESP
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [CW-1:0]     tmr, tmr_nxt;
   logic [TW-1:0]     tx_sh, tx_sh_nxt;
   logic [DATA_W-1:0] rx_q, rx_nxt;
   logic              rw_nxt;
   logic              ret_rx, ret_rx_nxt;
   logic              resume, resume_nxt;
   logic              err_nxt;
   logic              tx_bit_nxt;
   logic              ready_nxt;
   logic              req_nxt;
   logic              txv_nxt;
   logic              mode_nxt;
   logic              rspv_nxt;
   logic [DATA_W-1:0] rdata_nxt;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      tmr_nxt    = tmr;
      tx_sh_nxt  = tx_sh;
      rx_nxt     = rx_q;
      rw_nxt     = bus_rw;
      ret_rx_nxt = ret_rx;
      resume_nxt = resume;
      err_nxt    = 1'b0;
      tx_bit_nxt = 1'b0;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_nxt  = REQ;
               tx_sh_nxt  = {cmd_wdata, cmd_addr};
               rw_nxt     = cmd_rw;
               rx_nxt     = '0;
               cnt_nxt    = '0;
               tmr_nxt    = '0;
               resume_nxt = 1'b0;
            end
         end
         REQ: begin
            if (arb_grant) begin
               tmr_nxt = '0;
               // A resumed split skips the address phase and continues where it stopped.
               if (resume) begin
                  resume_nxt = 1'b0;
                  state_nxt  = ret_rx ? RX : WAIT_ACK;
               end else begin
                  state_nxt = ADDR;
                  cnt_nxt   = '0;
               end
            end
         end
         ADDR: begin
            if (cnt == ADDR_LAST) begin
               cnt_nxt   = '0;
               tmr_nxt   = '0;
               state_nxt = bus_rw ? WDATA : RX;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         WDATA: begin
            if (cnt == DATA_LAST) begin
               cnt_nxt   = '0;
               tmr_nxt   = '0;
               state_nxt = WAIT_ACK;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         WAIT_ACK: begin
            if (tgt_ack) begin
               state_nxt = RESP;
            end else if (tmr == TMR_LAST) begin
               state_nxt = RESP;
               err_nxt   = 1'b1;
            end else if (tgt_split) begin
               state_nxt  = SPLIT;
               ret_rx_nxt = 1'b0;
            end else begin
               tmr_nxt = tmr + CW'(1);
            end
         end
         RX: begin
            if (bus_rx_valid) begin
               rx_nxt = rx_q | (DATA_W'(bus_rx) << cnt);
            end
            // Completion (last bit or timeout) takes priority over a split request.
            if (bus_rx_valid && (cnt == DATA_LAST)) begin
               state_nxt = RESP;
            end else if (!bus_rx_valid && (tmr == TMR_LAST)) begin
               state_nxt = RESP;
               err_nxt   = 1'b1;
            end else if (tgt_split) begin
               state_nxt  = SPLIT;
               ret_rx_nxt = 1'b1;
               if (bus_rx_valid) begin
                  cnt_nxt = cnt + CW'(1);
               end
            end else if (bus_rx_valid) begin
               cnt_nxt = cnt + CW'(1);
               tmr_nxt = '0;
            end else begin
               tmr_nxt = tmr + CW'(1);
            end
         end
         SPLIT: begin
            if (split_resume) begin
               state_nxt  = REQ;
               resume_nxt = 1'b1;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Address and write data share one shift register, so the data phase follows seamlessly.
      if ((state_nxt == ADDR) || (state_nxt == WDATA)) begin
         tx_bit_nxt = tx_sh[0];
         tx_sh_nxt  = tx_sh >> 1;
      end

      if (state_nxt == IDLE) begin
         rw_nxt = 1'b0;
      end

      ready_nxt = (state_nxt == IDLE);
      req_nxt   = (state_nxt == REQ) || (state_nxt == ADDR) || (state_nxt == WDATA) ||
                  (state_nxt == WAIT_ACK) || (state_nxt == RX);
      txv_nxt   = (state_nxt == ADDR) || (state_nxt == WDATA);
      mode_nxt  = (state_nxt == WDATA) || (state_nxt == WAIT_ACK) || (state_nxt == RX);
      rspv_nxt  = (state_nxt == RESP);
      rdata_nxt = ((state_nxt == RESP) && !rw_nxt) ? rx_nxt : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         tmr          <= '0;
         tx_sh        <= '0;
         rx_q         <= '0;
         ret_rx       <= 1'b0;
         resume       <= 1'b0;
         cmd_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
         arb_req      <= 1'b0;
         bus_tx       <= 1'b0;
         bus_tx_valid <= 1'b0;
         bus_mode     <= 1'b0;
         bus_rw       <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         tmr          <= tmr_nxt;
         tx_sh        <= tx_sh_nxt;
         rx_q         <= rx_nxt;
         ret_rx       <= ret_rx_nxt;
         resume       <= resume_nxt;
         cmd_ready    <= ready_nxt;
         rsp_valid    <= rspv_nxt;
         rsp_rdata    <= rdata_nxt;
         rsp_err      <= err_nxt;
         arb_req      <= req_nxt;
         bus_tx       <= tx_bit_nxt;
         bus_tx_valid <= txv_nxt;
         bus_mode     <= mode_nxt;
         bus_rw       <= rw_nxt;
      end
   end

endmodule

// File: tb/tb_serial_init_port_fsm.sv
// Directed bench for serial_init_port_fsm: write, read with gaps, timeout, split/resume, held cmd_valid, mid-transfer reset.
module tb_serial_init_port_fsm;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int TO = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_rw = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          arb_req;
   logic          arb_grant = 1'b0;
   logic          bus_tx;
   logic          bus_tx_valid;
   logic          bus_mode;
   logic          bus_rw;
   logic          bus_rx = 1'b0;
   logic          bus_rx_valid = 1'b0;
   logic          tgt_ack = 1'b0;
   logic          tgt_split = 1'b0;
   logic          split_resume = 1'b0;

   always #5 clk = ~clk;

   serial_init_port_fsm #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_rw       (cmd_rw),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .arb_req      (arb_req),
      .arb_grant    (arb_grant),
      .bus_tx       (bus_tx),
      .bus_tx_valid (bus_tx_valid),
      .bus_mode     (bus_mode),
      .bus_rw       (bus_rw),
      .bus_rx       (bus_rx),
      .bus_rx_valid (bus_rx_valid),
      .tgt_ack      (tgt_ack),
      .tgt_split    (tgt_split),
      .split_resume (split_resume)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bus monitor, sampled on the inactive edge.
   logic [1:0] mon_q[$];
   int rsp_cnt = 0;
   int acc_cnt = 0;
   int overlap = 0;

   always @(negedge clk) begin
      if (bus_tx_valid) mon_q.push_back({bus_mode, bus_tx});
      if (rsp_valid) rsp_cnt++;
      if (cmd_valid && cmd_ready && rst_n) acc_cnt++;
      if (cmd_ready && (arb_req || bus_tx_valid)) overlap++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic issue(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int w;
      w = 0;
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_addr  = a;
      cmd_wdata = d;
      while (!cmd_ready && w < 50) begin
         tick();
         w++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic grant_now();
      int w;
      w = 0;
      while (!arb_req && w < 50) begin
         tick();
         w++;
      end
      chk("arb_req_wait", 32'(arb_req), 32'd1);
      arb_grant = 1'b1;
      tick();
      arb_grant = 1'b0;
   endtask

   task automatic rx_bit(input logic b, input int gap);
      repeat (gap) tick();
      bus_rx_valid = 1'b1;
      bus_rx       = b;
      tick();
      bus_rx_valid = 1'b0;
      bus_rx       = 1'b0;
   endtask

   task automatic chk_bus(input string tag, input int nbits, input logic [AW-1:0] a_exp,
                          input logic [DW-1:0] d_exp);
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int mode_bad;
      a = '0;
      d = '0;
      mode_bad = 0;
      chk({tag, "_nbits"}, 32'(mon_q.size()), 32'(nbits));
      foreach (mon_q[i]) begin
         if (i < AW) begin
            a[i] = mon_q[i][0];
            if (mon_q[i][1] != 1'b0) mode_bad++;
         end else if (i < AW + DW) begin
            d[i-AW] = mon_q[i][0];
            if (mon_q[i][1] != 1'b1) mode_bad++;
         end
      end
      chk({tag, "_addr"}, 32'(a), 32'(a_exp));
      if (nbits > AW) chk({tag, "_wdata"}, 32'(d), 32'(d_exp));
      chk({tag, "_mode"}, 32'(mode_bad), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] v;
      int r0;
      int a0;

      // Reset values
      ticks(3);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_arb_req", 32'(arb_req), 32'd0);
      chk("rst_tx_valid", 32'(bus_tx_valid), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_bus_rw", 32'(bus_rw), 32'd0);
      rst_n = 1'b1;
      ticks(2);

      // Write 0xA5 @0x1234, grant 2 cycles after arb_req, ack 3 cycles after last data bit
      mon_q.delete();
      issue(1'b1, 16'h1234, 8'hA5);
      chk("t1_busy", 32'(cmd_ready), 32'd0);
      chk("t1_bus_rw", 32'(bus_rw), 32'd1);
      ticks(2);
      arb_grant = 1'b1;
      tick();
      arb_grant = 1'b0;
      chk("t1_first_valid", 32'(bus_tx_valid), 32'd1);
      chk("t1_first_bit", 32'(bus_tx), 32'd0);
      ticks(24);
      chk("t1_wait_txv", 32'(bus_tx_valid), 32'd0);
      chk("t1_wait_mode", 32'(bus_mode), 32'd1);
      chk("t1_wait_req", 32'(arb_req), 32'd1);
      ticks(2);
      tgt_ack = 1'b1;
      tick();
      tgt_ack = 1'b0;
      chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t1_rsp_err", 32'(rsp_err), 32'd0);
      chk("t1_rsp_rdata", 32'(rsp_rdata), 32'd0);
      tick();
      chk("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
      chk("t1_ready_back", 32'(cmd_ready), 32'd1);
      chk_bus("t1", 24, 16'h1234, 8'hA5);

      // Read @0x00F0, target returns 0x3C with gaps
      mon_q.delete();
      issue(1'b0, 16'h00F0, 8'h00);
      grant_now();
      ticks(16);
      chk("t2_rx_mode", 32'(bus_mode), 32'd1);
      chk("t2_rx_txv", 32'(bus_tx_valid), 32'd0);
      v = 8'h3C;
      for (int i = 0; i < DW; i++) rx_bit(v[i], i % 3);
      chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t2_rdata", 32'(rsp_rdata), 32'h3C);
      chk("t2_err", 32'(rsp_err), 32'd0);
      tick();
      chk_bus("t2", 16, 16'h00F0, 8'h00);

      // Write with no ack: response exactly TO cycles after WAIT_ACK entry
      issue(1'b1, 16'hBEEF, 8'h11);
      grant_now();
      ticks(24);
      ticks(TO - 1);
      chk("t3_not_yet", 32'(rsp_valid), 32'd0);
      tick();
      chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t3_rsp_err", 32'(rsp_err), 32'd1);
      tick();

      // Read with split after 3 bits, resume 10 cycles later
      mon_q.delete();
      issue(1'b0, 16'h0F0F, 8'h00);
      grant_now();
      ticks(16);
      v = 8'h96;
      for (int i = 0; i < 3; i++) rx_bit(v[i], 1);
      tgt_split = 1'b1;
      tick();
      tgt_split = 1'b0;
      chk("t4_split_req", 32'(arb_req), 32'd0);
      bus_rx_valid = 1'b1;
      bus_rx = 1'b1;
      tick();
      bus_rx_valid = 1'b0;
      bus_rx = 1'b0;
      ticks(8);
      chk("t4_split_req_mid", 32'(arb_req), 32'd0);
      tick();
      split_resume = 1'b1;
      tick();
      split_resume = 1'b0;
      chk("t4_rereq", 32'(arb_req), 32'd1);
      arb_grant = 1'b1;
      tick();
      arb_grant = 1'b0;
      chk("t4_no_resend", 32'(bus_tx_valid), 32'd0);
      for (int i = 3; i < DW; i++) rx_bit(v[i], i % 2);
      chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t4_rdata", 32'(rsp_rdata), 32'h96);
      chk("t4_err", 32'(rsp_err), 32'd0);
      chk("t4_addr_once", 32'(mon_q.size()), 32'd16);
      tick();

      // cmd_valid held high: second command only after the response
      a0 = acc_cnt;
      cmd_valid = 1'b1;
      cmd_rw    = 1'b1;
      cmd_addr  = 16'h0001;
      cmd_wdata = 8'h5A;
      tick();
      grant_now();
      ticks(24);
      tgt_ack = 1'b1;
      tick();
      tgt_ack = 1'b0;
      chk("t5_rsp1", 32'(rsp_valid), 32'd1);
      chk("t5_one_accept", 32'(acc_cnt - a0), 32'd1);
      tick();
      chk("t5_ready", 32'(cmd_ready), 32'd1);
      cmd_addr  = 16'h0002;
      cmd_wdata = 8'h77;
      tick();
      cmd_valid = 1'b0;
      chk("t5_busy2", 32'(cmd_ready), 32'd0);
      chk("t5_two_accept", 32'(acc_cnt - a0), 32'd2);
      mon_q.delete();
      grant_now();
      ticks(24);
      tgt_ack = 1'b1;
      tick();
      tgt_ack = 1'b0;
      chk("t5_rsp2", 32'(rsp_valid), 32'd1);
      tick();
      chk_bus("t5", 24, 16'h0002, 8'h77);

      // Reset asserted mid-address phase
      issue(1'b1, 16'hCAFE, 8'h33);
      grant_now();
      ticks(5);
      chk("t6_in_addr", 32'(bus_tx_valid), 32'd1);
      r0 = rsp_cnt;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_txv", 32'(bus_tx_valid), 32'd0);
      chk("t6_rst_req", 32'(arb_req), 32'd0);
      chk("t6_rst_ready", 32'(cmd_ready), 32'd1);
      chk("t6_rst_rw", 32'(bus_rw), 32'd0);
      ticks(2);
      rst_n = 1'b1;
      tick();
      chk("t6_no_rsp", 32'(rsp_cnt - r0), 32'd0);
      mon_q.delete();
      issue(1'b0, 16'h0055, 8'h00);
      grant_now();
      ticks(16);
      v = 8'hE1;
      for (int i = 0; i < DW; i++) rx_bit(v[i], 0);
      chk("t6_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t6_rdata", 32'(rsp_rdata), 32'hE1);
      tick();
      chk_bus("t6", 16, 16'h0055, 8'h00);

      chk("rsp_total", 32'(rsp_cnt), 32'd7);
      chk("no_overlap", 32'(overlap), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
